// File: rtl/ms_prescaler_counter_if.sv
// Control/status bundle between the UART control path, the ms prescaler and the seconds stage.
interface ms_prescaler_counter_if #(
    parameter int TRIM_W = 8
);
    logic                     run_en;
    logic                     reconfig_en;
    logic        [9:0]        load_value;
    logic signed [TRIM_W-1:0] trim;
    logic        [9:0]        mil_sec;
    logic                     ms_tick;
    logic                     sec_tick;
    logic                     running;
    logic                     load_err;

    modport master (
        output run_en, reconfig_en, load_value, trim,
        input  mil_sec, ms_tick, sec_tick, running, load_err
    );

    modport slave (
        input  run_en, reconfig_en, load_value, trim,
        output mil_sec, ms_tick, sec_tick, running, load_err
    );
endinterface

// File: rtl/ms_prescaler_counter.sv
// Millisecond prescaler: divides clk by a trimmable period and keeps a 0..999 ms count with tick strobes.
module ms_prescaler_counter #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TRIM_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ms_prescaler_counter_if.slave bus
);
    localparam int P   = CLK_FREQ_HZ / 1000;
    localparam int P_W = $clog2(P) + 2;
    // One guard bit above the larger operand so P + trim can never wrap.
    localparam int EW  = ((P_W > TRIM_W + 1) ? P_W : TRIM_W + 1) + 1;

    localparam logic        [9:0]    MS_MAX = 10'd999;
    localparam logic signed [EW-1:0] P_S    = EW'(P);
    localparam logic signed [EW-1:0] E_MIN  = EW'(2);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_running;
    logic                     w_counting;

    logic        [EW-1:0]     r_presc;
    logic signed [TRIM_W-1:0] r_trim_lat;
    logic        [9:0]        r_mil_sec;
    logic                     r_ms_tick;
    logic                     r_sec_tick;
    logic                     r_load_err;

    logic        [EW-1:0]     w_period;
    logic        [EW-1:0]     w_period_m1;
    logic                     w_terminal;
    logic                     w_load_ok;
    logic                     w_load_bad;

    function automatic logic signed [EW-1:0] f_trimmed_period(
        input logic signed [TRIM_W-1:0] t
    );
        logic signed [EW-1:0] t_ext;
        t_ext = $signed({{(EW-TRIM_W){t[TRIM_W-1]}}, t});
        return P_S + t_ext;
    endfunction

    function automatic logic [EW-1:0] f_clamp_min2(
        input logic signed [EW-1:0] e
    );
        if (e < E_MIN) begin
            return $unsigned(E_MIN);
        end
        return $unsigned(e);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP: if (bus.run_en)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!bus.run_en) w_state_nxt = ST_STOP;
            default:                  w_state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        w_running  = 1'b0;
        w_counting = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_running  = 1'b1;
                w_counting = 1'b1;
            end
            default: begin
                w_running  = 1'b0;
                w_counting = 1'b0;
            end
        endcase
    end

    assign w_period    = f_clamp_min2(f_trimmed_period(r_trim_lat));
    assign w_period_m1 = w_period - EW'(1);
    // >= rather than == keeps the counter bounded even if the period ever shrank mid-count.
    assign w_terminal  = w_counting && (r_presc >= w_period_m1);
    assign w_load_ok   = bus.reconfig_en && (bus.load_value <= MS_MAX);
    assign w_load_bad  = bus.reconfig_en && (bus.load_value >  MS_MAX);

    // Stage p0: prescaler, ms count and registered strobes; an accepted load overrides an advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_trim_lat <= '0;
            r_mil_sec  <= '0;
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_ms_tick  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_mil_sec  <= bus.load_value;
                r_presc    <= '0;
                r_trim_lat <= bus.trim;
            end else if (w_terminal) begin
                r_presc    <= '0;
                r_trim_lat <= bus.trim;
                r_ms_tick  <= 1'b1;
                if (r_mil_sec == MS_MAX) begin
                    r_mil_sec  <= '0;
                    r_sec_tick <= 1'b1;
                end else begin
                    r_mil_sec  <= r_mil_sec + 10'd1;
                end
            end else if (w_counting) begin
                r_presc <= r_presc + EW'(1);
            end
        end
    end

    assign bus.mil_sec  = r_mil_sec;
    assign bus.ms_tick  = r_ms_tick;
    assign bus.sec_tick = r_sec_tick;
    assign bus.running  = w_running;
    assign bus.load_err = r_load_err;

    a_ms_range: assert property (@(posedge clk) disable iff (!reset)
        r_mil_sec <= MS_MAX);
    a_sec_implies_ms: assert property (@(posedge clk) disable iff (!reset)
        r_sec_tick |-> r_ms_tick);
    a_presc_bound: assert property (@(posedge clk) disable iff (!reset)
        r_presc <= w_period_m1);

endmodule

// File: tb/tb_ms_prescaler_counter.sv
// Scoreboard bench for ms_prescaler_counter at P=10: expected strobe events are queued with their cycle stamps.
module tb_ms_prescaler_counter;
    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   b;

    typedef struct {
        int         cyc;
        logic [9:0] ms;
        logic       tick;
        logic       sec;
        logic       err;
    } ev_t;

    ev_t q[$];

    ms_prescaler_counter_if #(.TRIM_W(8)) bus();

    ms_prescaler_counter #(
        .CLK_FREQ_HZ(10000),
        .TRIM_W     (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int ms, input logic tk, input logic sc, input logic er);
        ev_t e;
        e.cyc  = c;
        e.ms   = 10'(ms);
        e.tick = tk;
        e.sec  = sc;
        e.err  = er;
        q.push_back(e);
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every strobe the DUT presents must match the next queued expectation.
    always @(negedge clk) begin : mon
        ev_t e;
        if (reset === 1'b1 && (bus.ms_tick || bus.sec_tick || bus.load_err)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d mil_sec=%0d ms_tick=%0b sec_tick=%0b load_err=%0b, expected no event",
                         cyc, bus.mil_sec, bus.ms_tick, bus.sec_tick, bus.load_err);
            end else begin
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_mil_sec", bus.mil_sec, e.ms);
                chk("event_ms_tick", bus.ms_tick, e.tick);
                chk("event_sec_tick", bus.sec_tick, e.sec);
                chk("event_load_err", bus.load_err, e.err);
            end
        end
    end

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        bus.run_en      = 1'b0;
        bus.reconfig_en = 1'b0;
        bus.load_value  = '0;
        bus.trim        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mil_sec", bus.mil_sec, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_ms_tick", bus.ms_tick, 0);
        chk("rst_load_err", bus.load_err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_mil_sec", bus.mil_sec, 0);
        chk("rel_running", bus.running, 0);

        // 1: run from cleared state, 10-cycle period
        b = cyc;
        bus.run_en = 1'b1;
        push(b + 11, 1, 1, 0, 0);
        push(b + 21, 2, 1, 0, 0);
        push(b + 31, 3, 1, 0, 0);
        at_cyc(b + 1);
        chk("t1_running", bus.running, 1);
        at_cyc(b + 31);
        bus.run_en = 1'b0;
        at_cyc(b + 33);
        chk("t1_stopped", bus.running, 0);
        chk("t1_mil_sec", bus.mil_sec, 3);
        chk("t1_drained", q.size(), 0);

        // 2: load 997 then run through the wrap
        b = cyc;
        bus.reconfig_en = 1'b1;
        bus.load_value  = 10'd997;
        at_cyc(b + 1);
        bus.reconfig_en = 1'b0;
        bus.run_en      = 1'b1;
        chk("t2_loaded", bus.mil_sec, 997);
        chk("t2_load_no_tick", bus.ms_tick, 0);
        push(b + 12, 998, 1, 0, 0);
        push(b + 22, 999, 1, 0, 0);
        push(b + 32, 0, 1, 1, 0);

        // 3: trim +3, then -20 mid-period (clamps to 2), then back to 0
        at_cyc(b + 32);
        bus.trim = 8'sd3;
        push(b + 42, 1, 1, 0, 0);
        push(b + 55, 2, 1, 0, 0);
        at_cyc(b + 48);
        bus.trim = -8'sd20;
        push(b + 57, 3, 1, 0, 0);
        push(b + 59, 4, 1, 0, 0);
        at_cyc(b + 57);
        bus.trim = 8'sd0;
        push(b + 69, 5, 1, 0, 0);

        // 4: hold at prescaler 6 for 50 cycles, resume
        at_cyc(b + 74);
        bus.run_en = 1'b0;
        at_cyc(b + 100);
        chk("t4_hold_running", bus.running, 0);
        chk("t4_hold_mil_sec", bus.mil_sec, 5);
        push(b + 129, 6, 1, 0, 0);
        at_cyc(b + 124);
        bus.run_en = 1'b1;
        at_cyc(b + 129);
        bus.run_en = 1'b0;
        at_cyc(b + 131);
        chk("t4_drained", q.size(), 0);

        // 5: rejected load, then a load colliding with terminal count
        b = cyc;
        bus.reconfig_en = 1'b1;
        bus.load_value  = 10'd1000;
        push(b + 1, 6, 0, 0, 1);
        at_cyc(b + 1);
        bus.reconfig_en = 1'b0;
        at_cyc(b + 2);
        chk("t5_bad_unchanged", bus.mil_sec, 6);
        bus.reconfig_en = 1'b1;
        bus.load_value  = 10'd100;
        bus.run_en      = 1'b1;
        at_cyc(b + 3);
        bus.reconfig_en = 1'b0;
        chk("t5_load100", bus.mil_sec, 100);
        at_cyc(b + 12);
        bus.reconfig_en = 1'b1;
        bus.load_value  = 10'd500;
        at_cyc(b + 13);
        bus.reconfig_en = 1'b0;
        chk("t5_load500", bus.mil_sec, 500);
        chk("t5_tc_no_tick", bus.ms_tick, 0);
        push(b + 23, 501, 1, 0, 0);

        // 6: asynchronous reset mid-period at 42
        at_cyc(b + 23);
        bus.reconfig_en = 1'b1;
        bus.load_value  = 10'd42;
        at_cyc(b + 24);
        bus.reconfig_en = 1'b0;
        chk("t6_load42", bus.mil_sec, 42);
        at_cyc(b + 28);
        #2;
        reset      = 1'b0;
        bus.run_en = 1'b0;
        #1;
        chk("t6_async_mil_sec", bus.mil_sec, 0);
        chk("t6_async_running", bus.running, 0);
        chk("t6_async_ms_tick", bus.ms_tick, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        b = cyc;
        at_cyc(b + 30);
        chk("t6_idle_mil_sec", bus.mil_sec, 0);
        chk("t6_idle_running", bus.running, 0);
        bus.run_en = 1'b1;
        push(b + 41, 1, 1, 0, 0);
        at_cyc(b + 45);
        chk("t6_restart_running", bus.running, 1);
        chk("final_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ms_prescaler_counter.md
Name: ms_prescaler_counter

Overview:
- Upstream stage of the seconds counter: turns the system clock into a 0..999 millisecond count (`mil_sec`) plus tick strobes.
- The seconds stage counts on the millisecond wrap; this block sets its timebase accuracy.
- Supports run/stop, a time-set load from the UART control path, and a signed trim of the millisecond period for oscillator calibration.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency in Hz. Nominal ms period P = CLK_FREQ_HZ/1000 cycles; CLK_FREQ_HZ must be ≥2000.
- TRIM_W, 8, width of the signed two's-complement trim input.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- run_en  in  1  1 = count, 0 = hold.
- reconfig_en  in  1  single-cycle load strobe.
- load_value  in  10  millisecond value to load.
- trim  in  TRIM_W  signed cycle offset added to P.
- mil_sec  out  10  current millisecond, 0..999.
- ms_tick  out  1  1-cycle pulse on every `mil_sec` advance.
- sec_tick  out  1  1-cycle pulse on the 999→0 wrap.
- running  out  1  1 while in RUN state.
- load_err  out  1  1-cycle pulse on a rejected load.

Behaviour:
- Reset (reset=0, asynchronous):
  - `mil_sec`=0, prescaler=0, trim_lat=0, state=STOP.
  - All pulse outputs 0, `running`=0.
  - Taking effect mid-count aborts immediately; no tick is emitted.
- State machine, two states:
  - STOP→RUN when run_en=1 at a clock edge.
  - RUN→STOP when run_en=0.
  - `running` is a registered copy of the state (1 cycle after the run_en edge).
- Effective period:
  - E = P + trim_lat, clamped to a minimum of 2 cycles.
  - Compute in a signed width ≥ max(ceil(log2(P))+2, TRIM_W+1); no wrap allowed.
- Trim latching:
  - trim_lat samples `trim` at every ms boundary and at every load.
  - Mid-period changes of `trim` do not affect the current period.
- Prescaler (RUN only):
  - Counts 0..E-1.
  - At E-1: prescaler→0, `mil_sec` advances, `ms_tick`=1 for the following cycle.
  - First ms_tick after entering RUN from a cleared prescaler occurs E cycles after entry.
- Millisecond count:
  - 0..998 → +1.
  - 999 → 0, with `sec_tick`=1 in the same cycle as `ms_tick`.
  - `mil_sec` never leaves 0..999.
- STOP:
  - Prescaler and `mil_sec` hold; no ticks.
  - Re-entering RUN resumes from the held prescaler value; the partial period is not lost.
- Load (reconfig_en=1, either state):
  - load_value ≤999: `mil_sec`←load_value, prescaler←0, trim_lat←trim. State unchanged.
  - load_value >999: `mil_sec` and prescaler unchanged, `load_err`=1 for one cycle. State unchanged.
  - Load coinciding with a prescaler terminal count: load wins; no ms_tick/sec_tick that cycle.
  - Load of 999 does not emit sec_tick; the next advance wraps to 0 with sec_tick.
- Simultaneous run_en=0 and terminal count: the advance still completes that cycle; the hold applies from the next cycle.
- Output timing: all outputs registered; no combinational path from inputs to outputs.
- Downstream contract: `mil_sec` changes only on a tick or an accepted load, so change-detection in the seconds stage sees exactly one change per ms.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=10000 (P=10), trim=0.
1. Reset then run_en=1: `running`=1 after 1 cycle; first ms_tick 10 cycles after RUN entry; `mil_sec` 0→1; every subsequent tick exactly 10 cycles apart.
2. Load 997 then run: ticks give 998, 999, then 0 with sec_tick=1 on that cycle only; no sec_tick on the load itself.
3. Trim: trim=+3 → next period 13 cycles. Change trim to −20 mid-period → current period stays 13; the following period clamps to 2 cycles.
4. run_en=0 at prescaler=6 for 50 cycles: no ticks, `mil_sec` frozen; after resume, next tick comes 4 cycles later.
5. reconfig_en with load_value=1000 → load_err pulse, `mil_sec` unchanged. Load 500 on a terminal-count cycle → `mil_sec`=500, no ms_tick, prescaler=0.
6. Assert reset low asynchronously mid-period at `mil_sec`=42 → `mil_sec`=0 and `running`=0 before the next clock edge; no tick after release until run_en restarts.
